touch_packet_rx: RTL



---
 rtl/touch_packet_rx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/touch_packet_rx.sv
// Touch controller receiver: 8N1 UART deserialiser plus 5-byte coordinate packet parser.
// Optional inter-byte timeout for partial packets is enabled by defining TOUCH_RX_TIMEOUT_EN.
module touch_packet_rx #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic        pt_pen,
  output logic [11:0] pt_x,
  output logic [11:0] pt_y,
  output logic        frame_err,
  output logic        overrun,
  output logic [1:0]  dbg_rx_state,
  output logic [2:0]  dbg_parse_state
);
  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {P_HDR, P_XLO, P_XHI, P_YLO, P_YHI} p_state_e;

  logic             sync1_q, sync2_q, rxd_prev_q;
  logic             rxd_s, fall, tick;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic             byte_strobe, frame_err_d, frame_err_q;

  p_state_e         p_state_q, p_state_d;
  logic             pen_q, pen_d;
  logic [6:0]       xlo_q, xlo_d, ylo_q, ylo_d;
  logic [4:0]       xhi_q, xhi_d;
  logic             commit;

  logic             pt_valid_q, pt_valid_d, pt_pen_q, pt_pen_d, overrun_q, overrun_d;
  logic [11:0]      pt_x_q, pt_x_d, pt_y_q, pt_y_d;

  assign rxd_s = sync2_q;
  assign fall  = rxd_prev_q & ~rxd_s;
  assign tick  = (div_cnt_q == DIV_W'(DIV - 1));

  // Synchroniser flops reset high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      rxd_prev_q <= sync2_q;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_strobe = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (fall) begin
        rx_state_d = RX_START;
        div_cnt_d  = '0;
        os_cnt_d   = '0;
      end
      RX_START: if (tick) begin
        if (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
          os_cnt_d   = '0;
          bit_cnt_d  = '0;
          rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
        end else os_cnt_d = os_cnt_q + OS_W'(1);
      end
      RX_DATA: if (tick) begin
        if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
          os_cnt_d  = '0;
          shift_d   = {rxd_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end else os_cnt_d = os_cnt_q + OS_W'(1);
      end
      RX_STOP: if (tick) begin
        if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
          os_cnt_d    = '0;
          rx_state_d  = RX_IDLE;
          byte_strobe = rxd_s;
          frame_err_d = ~rxd_s;
        end else os_cnt_d = os_cnt_q + OS_W'(1);
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

`ifdef TOUCH_RX_TIMEOUT_EN
  localparam int GAP_MAX = TIMEOUT_BITS * OVERSAMPLE;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             gap_expired;
  assign gap_expired = (gap_cnt_q == GAP_W'(GAP_MAX));

  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (byte_strobe || p_state_q == P_HDR) gap_cnt_d = '0;
    else if (tick && !gap_expired) gap_cnt_d = gap_cnt_q + GAP_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gap_cnt_q <= '0;
    else       gap_cnt_q <= gap_cnt_d;
  end
`else
  logic gap_expired;
  assign gap_expired = 1'b0;
`endif

  // A byte with bit7 set is always a header candidate, whatever state the parser is in.
  always_comb begin
    p_state_d = p_state_q;
    pen_d     = pen_q;
    xlo_d     = xlo_q;
    xhi_d     = xhi_q;
    ylo_d     = ylo_q;
    commit    = 1'b0;
    if (byte_strobe) begin
      if (shift_q[7]) begin
        if (shift_q[7:1] == 7'h40) begin
          pen_d     = shift_q[0];
          p_state_d = P_XLO;
        end else p_state_d = P_HDR;
      end else begin
        case (p_state_q)
          P_XLO: begin xlo_d = shift_q[6:0]; p_state_d = P_XHI; end
          P_XHI: begin xhi_d = shift_q[4:0]; p_state_d = P_YLO; end
          P_YLO: begin ylo_d = shift_q[6:0]; p_state_d = P_YHI; end
          P_YHI: begin commit = 1'b1;        p_state_d = P_HDR; end
          default: p_state_d = P_HDR;
        endcase
      end
    end else if (gap_expired && p_state_q != P_HDR) begin
      p_state_d = P_HDR;
    end
  end

  always_comb begin
    pt_valid_d = pt_valid_q;
    pt_pen_d   = pt_pen_q;
    pt_x_d     = pt_x_q;
    pt_y_d     = pt_y_q;
    overrun_d  = commit & pt_valid_q & ~pt_ready;
    if (pt_valid_q && pt_ready) pt_valid_d = 1'b0;
    if (commit) begin
      pt_valid_d = 1'b1;
      pt_pen_d   = pen_q;
      pt_x_d     = {xhi_q, xlo_q};
      pt_y_d     = {shift_q[4:0], ylo_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q  <= RX_IDLE;
      div_cnt_q   <= '0;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      p_state_q   <= P_HDR;
      pen_q       <= 1'b0;
      xlo_q       <= '0;
      xhi_q       <= '0;
      ylo_q       <= '0;
      pt_valid_q  <= 1'b0;
      pt_pen_q    <= 1'b0;
      pt_x_q      <= '0;
      pt_y_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      div_cnt_q   <= div_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      p_state_q   <= p_state_d;
      pen_q       <= pen_d;
      xlo_q       <= xlo_d;
      xhi_q       <= xhi_d;
      ylo_q       <= ylo_d;
      pt_valid_q  <= pt_valid_d;
      pt_pen_q    <= pt_pen_d;
      pt_x_q      <= pt_x_d;
      pt_y_q      <= pt_y_d;
      overrun_q   <= overrun_d;
    end
  end

  // Point handshake: a point transfers on any cycle where pt_valid && pt_ready.
  assign pt_valid        = pt_valid_q;
  assign pt_pen          = pt_pen_q;
  assign pt_x            = pt_x_q;
  assign pt_y            = pt_y_q;
  assign frame_err       = frame_err_q;
  assign overrun         = overrun_q;
  assign dbg_rx_state    = rx_state_q;
  assign dbg_parse_state = p_state_q;
endmodule
